// File: rtl/key_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the key event arbiter: per-key FSM states,
// event type encoding and the ms-to-cycle conversion helpers.
package key_pkg;

  // Per-key press classifier states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    LONGHELD = 2'd2
  } key_state_e;

  // Event type as carried on evt_long
  typedef enum logic {
    EVT_SHORT = 1'b0,
    EVT_LONG  = 1'b1
  } evt_type_e;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_fre, input int unsigned ms);
    return (clk_fre / 1000) * ms;
  endfunction

  function automatic int unsigned long_cyc(input int unsigned clk_fre, input int unsigned long_ms);
    return ms_to_cyc(clk_fre, long_ms);
  endfunction

  function automatic int unsigned rel_cyc(input int unsigned clk_fre, input int unsigned rel_ms);
    return ms_to_cyc(clk_fre, rel_ms);
  endfunction

  // Counter width: one spare bit above the constant so saturation never aliases it
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return $clog2(cyc) + 1;
  endfunction

endpackage

// File: rtl/key_press_classifier.sv
`timescale 1ns/1ps
// Per-key press classifier: tracks one key from its debounced press pulse
// until release and classifies the press as short or long.
// Ports:
//   clk_in       clock
//   sys_rst      asynchronous active-high reset
//   key_flag     one-cycle debounced press pulse
//   key_n        synchronised raw key level, 0 = pressed
//   post_c       event posted this cycle (combinational)
//   post_type_c  type of the posted event (combinational)
module key_press_classifier
  import key_pkg::*;
#(
  parameter int unsigned CLK_FRE = 50_000_000,
  parameter int unsigned LONG_MS = 1000,
  parameter int unsigned REL_MS  = 20
) (
  input  logic      clk_in,
  input  logic      sys_rst,
  input  logic      key_flag,
  input  logic      key_n,
  output logic      post_c,
  output evt_type_e post_type_c
);

  localparam int unsigned LONG_CYC = long_cyc(CLK_FRE, LONG_MS);
  localparam int unsigned REL_CYC  = rel_cyc(CLK_FRE, REL_MS);
  localparam int unsigned HOLD_W   = cnt_width(LONG_CYC);
  localparam int unsigned REL_W    = cnt_width(REL_CYC);

  key_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [REL_W-1:0]  rel_q, rel_d, rel_inc;
  logic              long_hit, rel_hit;

  // Saturating increments
  assign hold_inc = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
  assign rel_inc  = (rel_q == '1) ? rel_q : rel_q + REL_W'(1);

  assign long_hit = (hold_q == HOLD_W'(LONG_CYC - 1));
  // Release fires on the REL_CYC-th consecutive high cycle
  assign rel_hit  = key_n && (rel_q == REL_W'(REL_CYC - 1));

  // State and counter registers
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
    end
  end

  // Next state, counter update and event posting
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rel_d       = rel_q;
    post_c      = 1'b0;
    post_type_c = EVT_SHORT;
    case (state_q)
      IDLE: begin
        if (key_flag) begin
          state_d = HELD;
          hold_d  = '0;
          rel_d   = '0;
        end
      end
      HELD: begin
        hold_d = hold_inc;
        rel_d  = key_n ? rel_inc : '0;
        // Long classification takes priority over a coincident release
        if (long_hit) begin
          state_d     = LONGHELD;
          post_c      = 1'b1;
          post_type_c = EVT_LONG;
        end else if (rel_hit) begin
          state_d     = IDLE;
          post_c      = 1'b1;
          post_type_c = EVT_SHORT;
        end
      end
      LONGHELD: begin
        hold_d = hold_inc;
        rel_d  = key_n ? rel_inc : '0;
        if (rel_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/key_event_arbiter.sv
`timescale 1ns/1ps
// Key event arbiter: classifies presses on KEY_NUM keys, holds one pending
// event per key and serialises them round-robin onto a valid/ready output.
// Ports:
//   clk_in     clock
//   sys_rst    asynchronous active-high reset
//   key_flag   per-key one-cycle debounced press pulses
//   key_n      per-key synchronised raw levels, 0 = pressed
//   evt_valid  event available
//   evt_ready  consumer accepts the event while evt_valid=1
//   evt_id     key index of the event
//   evt_long   1 = long press, 0 = short press
//   evt_ovf    per-key one-cycle pulse when an event is dropped
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int unsigned CLK_FRE = 50_000_000,
  parameter int unsigned KEY_NUM = 4,
  parameter int unsigned LONG_MS = 1000,
  parameter int unsigned REL_MS  = 20
) (
  input  logic                       clk_in,
  input  logic                       sys_rst,
  input  logic [KEY_NUM-1:0]         key_flag,
  input  logic [KEY_NUM-1:0]         key_n,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(KEY_NUM)-1:0] evt_id,
  output logic                       evt_long,
  output logic [KEY_NUM-1:0]         evt_ovf
);

  localparam int unsigned ID_W = $clog2(KEY_NUM);

  logic      [KEY_NUM-1:0] post_c;
  evt_type_e               post_type_c [KEY_NUM];

  logic [KEY_NUM-1:0] pend_q, pend_d;
  logic [KEY_NUM-1:0] pend_long_q, pend_long_d;
  logic [KEY_NUM-1:0] ovf_c;
  logic [KEY_NUM-1:0] gnt_c;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    win_c;
  logic               load_c;

  // One classifier per key
  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_press_classifier #(
      .CLK_FRE (CLK_FRE),
      .LONG_MS (LONG_MS),
      .REL_MS  (REL_MS)
    ) u_cls (
      .clk_in      (clk_in),
      .sys_rst     (sys_rst),
      .key_flag    (key_flag[g]),
      .key_n       (key_n[g]),
      .post_c      (post_c[g]),
      .post_type_c (post_type_c[g])
    );
  end

  // Round-robin search starting one past the last winner
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win_c = '0;
    for (int off = 1; off <= int'(KEY_NUM); off++) begin
      idx = (int'(rr_ptr_q) + off) % int'(KEY_NUM);
      if (!found && pend_q[ID_W'(idx)]) begin
        found = 1'b1;
        win_c = ID_W'(idx);
      end
    end
  end

  // Output slot is free or being emptied, and something is waiting
  assign load_c = (!evt_valid || evt_ready) && (|pend_q);

  // Pending storage update; a grant frees the slot for a same-cycle post
  always_comb begin
    gnt_c       = '0;
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    ovf_c       = '0;
    if (load_c) begin
      gnt_c[win_c] = 1'b1;
    end
    for (int i = 0; i < int'(KEY_NUM); i++) begin
      if (gnt_c[i]) begin
        pend_d[i] = 1'b0;
      end
      if (post_c[i]) begin
        if (pend_q[i] && !gnt_c[i]) begin
          ovf_c[i] = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = (post_type_c[i] == EVT_LONG);
        end
      end
    end
  end

  // Pending registers, output register and round-robin pointer
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      pend_q      <= '0;
      pend_long_q <= '0;
      rr_ptr_q    <= ID_W'(KEY_NUM - 1);
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_long    <= 1'b0;
      evt_ovf     <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      evt_ovf     <= ovf_c;
      if (load_c) begin
        evt_valid <= 1'b1;
        evt_id    <= win_c;
        evt_long  <= pend_long_q[win_c];
        rr_ptr_q  <= win_c;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
`timescale 1ns/1ps
// Directed bench for key_event_arbiter with CLK_FRE=1000, KEY_NUM=4,
// LONG_MS=1000, REL_MS=20 (LONG_CYC=1000, REL_CYC=20).
module tb_key_event_arbiter;

  localparam int unsigned KN = 4;

  logic          clk_in = 1'b0;
  logic          sys_rst;
  logic [KN-1:0] key_flag;
  logic [KN-1:0] key_n;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_id;
  logic          evt_long;
  logic [KN-1:0] evt_ovf;

  int errors = 0;
  int checks = 0;
  int now    = 0;
  int t0     = 0;
  int acc_cnt = 0;
  int ovf_cnt = 0;
  int acc_key [KN] = '{default: 0};
  int base_acc;
  int base_k1;

  key_event_arbiter #(
    .CLK_FRE (1000),
    .KEY_NUM (KN),
    .LONG_MS (1000),
    .REL_MS  (20)
  ) dut (
    .clk_in    (clk_in),
    .sys_rst   (sys_rst),
    .key_flag  (key_flag),
    .key_n     (key_n),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_long  (evt_long),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk_in = ~clk_in;

  // Count accepted events and overflow pulses
  always @(posedge clk_in) begin
    if (!sys_rst) begin
      if (evt_valid && evt_ready) begin
        acc_cnt++;
        acc_key[evt_id]++;
      end
      for (int i = 0; i < int'(KN); i++) begin
        if (evt_ovf[i]) ovf_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
    now += n;
  endtask

  // Advance to the negedge inside cycle k relative to the last mark
  task automatic at(input int k);
    if (t0 + k > now) cyc(t0 + k - now);
  endtask

  task automatic mark();
    t0 = now;
  endtask

  task automatic pulse_reset();
    sys_rst = 1'b1;
    cyc(1);
    sys_rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    sys_rst   = 1'b1;
    key_flag  = '0;
    key_n     = '1;
    evt_ready = 1'b1;
    cyc(1);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id",    32'(evt_id),    32'd0);
    check("rst_long",  32'(evt_long),  32'd0);
    check("rst_ovf",   32'(evt_ovf),   32'd0);
    cyc(2);
    sys_rst = 1'b0;
    cyc(2);

    // Short press on key 1: post in cycle 319, visible in cycle 321
    mark();
    key_flag[1] = 1'b1; key_n[1] = 1'b0;
    at(1);   key_flag = '0;
    at(300); key_n[1] = 1'b1;
    at(320); check("short_early", 32'(evt_valid), 32'd0);
    at(321); check("short_valid", 32'(evt_valid), 32'd1);
             check("short_id",    32'(evt_id),    32'd1);
             check("short_long",  32'(evt_long),  32'd0);
    at(322); check("short_drop",  32'(evt_valid), 32'd0);
    at(360); check("short_count", 32'(acc_cnt),   32'd1);

    // Long press on key 2: hold_cnt hits 999 in cycle 1000
    mark();
    key_flag[2] = 1'b1; key_n[2] = 1'b0;
    at(1);    key_flag = '0;
    at(1001); check("long_early", 32'(evt_valid), 32'd0);
    at(1002); check("long_valid", 32'(evt_valid), 32'd1);
              check("long_id",    32'(evt_id),    32'd2);
              check("long_long",  32'(evt_long),  32'd1);
    at(1003); check("long_drop",  32'(evt_valid), 32'd0);
    at(1500); key_n[2] = 1'b1;
    at(1560); check("long_norel", 32'(acc_cnt),   32'd2);
              check("long_idle",  32'(evt_valid), 32'd0);

    // Release glitch on key 0: high 10, low 10, then high for good
    mark();
    key_flag[0] = 1'b1; key_n[0] = 1'b0;
    at(1);  key_flag = '0;
    at(50); key_n[0] = 1'b1;
    at(60); key_n[0] = 1'b0;
    at(70); key_n[0] = 1'b1;
    at(72); check("glitch_none",  32'(evt_valid), 32'd0);
    at(90); check("glitch_early", 32'(evt_valid), 32'd0);
    at(91); check("glitch_valid", 32'(evt_valid), 32'd1);
            check("glitch_id",    32'(evt_id),    32'd0);
            check("glitch_long",  32'(evt_long),  32'd0);
    at(92); check("glitch_drop",  32'(evt_valid), 32'd0);

    // Round-robin from a fresh pointer: keys 0,1,3 together, then 0,3
    pulse_reset();
    mark();
    key_flag = 4'b1011; key_n = 4'b0100;
    at(1);  key_flag = '0;
    at(5);  key_n = '1;
    at(25); check("rr_early", 32'(evt_valid), 32'd0);
    at(26); check("rr_v0",    32'(evt_valid), 32'd1);
            check("rr_id0",   32'(evt_id),    32'd0);
    at(27); check("rr_id1",   32'(evt_id),    32'd1);
    at(28); check("rr_id3",   32'(evt_id),    32'd3);
    at(29); check("rr_end",   32'(evt_valid), 32'd0);
    mark();
    key_flag = 4'b1001; key_n = 4'b0110;
    at(1);  key_flag = '0;
    at(5);  key_n = '1;
    at(26); check("rr2_id0",  32'(evt_id),    32'd0);
            check("rr2_v0",   32'(evt_valid), 32'd1);
    at(27); check("rr2_id3",  32'(evt_id),    32'd3);
    at(28); check("rr2_end",  32'(evt_valid), 32'd0);

    // Backpressure: key 0 in the output slot, key 1 pending, key 1 posts again
    base_k1 = acc_key[1];
    mark();
    evt_ready = 1'b0;
    key_flag = 4'b0011; key_n = 4'b1100;
    at(1);  key_flag = '0;
    at(2);  key_n = '1;
    at(22); check("bp_early",  32'(evt_valid), 32'd0);
    at(23); check("bp_valid",  32'(evt_valid), 32'd1);
            check("bp_id",     32'(evt_id),    32'd0);
    at(30); key_flag[1] = 1'b1; key_n[1] = 1'b0;
    at(31); key_flag = '0;
    at(32); key_n[1] = 1'b1;
    at(51); check("bp_ovf_pre",  32'(evt_ovf),   32'd0);
    at(52); check("bp_ovf",      32'(evt_ovf),   32'b0010);
            check("bp_hold_v",   32'(evt_valid), 32'd1);
            check("bp_hold_id",  32'(evt_id),    32'd0);
    at(53); check("bp_ovf_post", 32'(evt_ovf),   32'd0);
    at(60); check("bp_stable",   32'(evt_id),    32'd0);
            evt_ready = 1'b1;
    at(61); check("bp_k1_valid", 32'(evt_valid), 32'd1);
            check("bp_k1_id",    32'(evt_id),    32'd1);
            check("bp_k1_long",  32'(evt_long),  32'd0);
    at(62); check("bp_end",      32'(evt_valid), 32'd0);
    at(90); check("bp_k1_count", 32'(acc_key[1] - base_k1), 32'd1);
            check("bp_ovf_count", 32'(ovf_cnt), 32'd1);

    // Async reset during a stalled output, a pending event and a HELD key
    base_acc = acc_cnt;
    mark();
    evt_ready = 1'b0;
    key_flag = 4'b1010; key_n = 4'b0101;
    at(1);  key_flag = '0;
    at(3);  key_n = 4'b1111;
    at(30); key_flag[0] = 1'b1; key_n[0] = 1'b0;
    at(31); key_flag = '0;
    at(40); check("ar_stall_v",  32'(evt_valid), 32'd1);
            check("ar_stall_id", 32'(evt_id),    32'd3);
    at(50); sys_rst = 1'b1;
            #1;
            check("ar_valid_now", 32'(evt_valid), 32'd0);
            check("ar_id_now",    32'(evt_id),    32'd0);
    at(51); sys_rst = 1'b0; key_n = '1; evt_ready = 1'b1;
    at(60);  check("ar_quiet1", 32'(evt_valid), 32'd0);
    at(120); check("ar_quiet2", 32'(evt_valid), 32'd0);
             check("ar_noevt",  32'(acc_cnt - base_acc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
